demux_1to2_stream: RTL and testbench
====================================

# demux_1to2_stream

Registered 1:2 stream demultiplexer: the inverse of the team's 2:1 select mux. It accepts words on a single valid/ready input and steers each word to one of two valid/ready output channels. The channel comes from an explicit select bit or from an internal round-robin pointer. Each output channel holds one word in a register stage and keeps a per-channel word counter. The block sits between a shared producer and two independent consumers in the datapath.

## Interface
- WIDTH, 8, data word width in bits
- CNT_W, 8, width of each per-channel accepted-word counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  input word
- in_s  in  1  destination channel (0 -> out0, 1 -> out1); used only when auto_mode=0
- auto_mode  in  1  1 = round-robin steering, in_s ignored
- out0_valid / out1_valid  out  1  channel holds a word
- out0_ready / out1_ready  in  1  consumer takes the word
- out0_data / out1_data  out  WIDTH  held word
- cnt0 / cnt1  out  CNT_W  words accepted for channel 0 / 1
- rr_ptr  out  1  current round-robin pointer (debug)

## Operation
- Destination: dest = auto_mode ? rr_ptr : in_s (combinational).
- Channel k is free when outk_valid=0, or when outk_valid=1 and outk_ready=1 (draining this cycle).
- in_ready = free(dest); it is a combinational function of in_s, auto_mode, rr_ptr, outk_valid and outk_ready.
- Accept when in_valid & in_ready:
  - outdest_data <= in_data and outdest_valid <= 1.
  - cntdest increments modulo 2^CNT_W; 2^CNT_W-1 wraps to 0 with no flag.
- rr_ptr toggles on every accept made while auto_mode=1. It holds otherwise, including on accepts made with auto_mode=0.
- Drain: if outk_valid & outk_ready and channel k is not refilled in the same cycle, then outk_valid <= 0. outk_data holds its last value.
- Simultaneous drain and refill on the same channel: outk_valid stays 1 and outk_data takes the new word. No bubble, no loss.
- Channels are independent:
  - A stalled channel blocks only words destined for it.
  - A word for the free channel passes even while the other channel is full.
  - Ordering is guaranteed only within a channel.
- in_data, in_s and auto_mode must be held stable while in_valid=1 and in_ready=0. The block does not latch them before acceptance.
- The block never drops or duplicates a word. At most one word is accepted per cycle.

## Timing
- Latency: a word accepted at edge N is visible on outk_data/outk_valid after edge N, i.e. during cycle N+1.
- Throughput: 1 word per cycle when the consumers keep outk_ready=1.
- Reset (rst=1 sampled at an edge):
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - cnt0 = cnt1 = 0
  - rr_ptr = 0
- in_ready during reset follows the combinational rule applied to the reset state. in_valid is ignored while rst=1: nothing is accepted and no counter changes.
- Reset mid-operation discards held words. Counters and pointer clear on the same edge, with no partial update.
- Switching auto_mode between words takes effect in the same cycle. rr_ptr keeps its value across mode changes.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 -> both valids 0, both data 0, cnt0=cnt1=0, rr_ptr=0, no accept.
- Explicit steering: auto_mode=0, both readys 1, send 0xA5 (s=0), 0x3C (s=1), 0x11 (s=0) on consecutive cycles -> out0 shows 0xA5, then 0x11; out1 shows 0x3C; each word appears one cycle after accept; cnt0=2, cnt1=1.
- Round-robin: auto_mode=1, send 0x01..0x04 back to back -> out0 gets 0x01 then 0x03, out1 gets 0x02 then 0x04; rr_ptr returns to 0; cnt0=cnt1=2.
- Independent backpressure: out0_ready=0 with out0 already holding 0x55, auto_mode=0:
  - Word 0x77 with s=0 -> in_ready=0 and the word waits.
  - Change the pending word to 0x66 with s=1 -> accepted, out1_data=0x66.
  - Raise out0_ready -> out0 drains 0x55.
- Drain plus refill: out0_valid=1 holding 0x10, out0_ready=1, accept 0x20 for channel 0 in the same cycle -> out0_valid stays 1 and out0_data=0x20 next cycle.
- Counter wrap plus mid-run reset, CNT_W=8:
  - Push 256 words to channel 1 -> cnt1 wraps to 0.
  - Push 3 more words, then pulse rst while out1_valid=1 -> cnt1=0, out1_valid=0, rr_ptr=0 on the next cycle.

Source files
------------

// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for the 1:2 demultiplexer: one valid/ready input
// channel carrying a select bit and a mode bit, and two valid/ready
// output channels.
interface demux_1to2_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_s;
    logic             auto_mode;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    // Environment view: drives the producer side and the consumer readys.
    modport master (
        output in_valid, in_data, in_s, auto_mode, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    // Demultiplexer view.
    modport slave (
        input  in_valid, in_data, in_s, auto_mode, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 stream demultiplexer. Each input word is steered to
// one of two output register stages, chosen by in_s or by a
// round-robin pointer. Each channel counts the words it accepted.
module demux_1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1to2_stream_if.slave    bus,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1,
    output logic                  rr_ptr
);

    logic       rr_ptr_reg;
    logic       dest;
    logic [1:0] out_ready;
    logic [1:0] out_valid;
    logic [1:0] chan_free;
    logic       in_ready_int;
    logic       accept;

    assign out_ready = {bus.out1_ready, bus.out0_ready};

    // Destination and handshake: a channel is free when empty or draining.
    always_comb begin
        dest         = bus.auto_mode ? rr_ptr_reg : bus.in_s;
        chan_free    = ~out_valid | out_ready;
        in_ready_int = chan_free[dest];
        accept       = bus.in_valid & in_ready_int;
    end

    assign bus.in_ready = in_ready_int;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Channel stage: refill wins over drain so a simultaneous
            // drain and refill keeps valid high with the new word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    cnt_reg   <= '0;
                end else if (accept && (dest == 1'(gi))) begin
                    valid_reg <= 1'b1;
                    data_reg  <= bus.in_data;
                    cnt_reg   <= cnt_reg + 1'b1;
                end else if (valid_reg && out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi] = valid_reg;
        end
    endgenerate

    // Round-robin pointer advances only on accepts made in auto mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (accept && bus.auto_mode) begin
            rr_ptr_reg <= ~rr_ptr_reg;
        end
    end

    assign bus.out0_valid = g_ch[0].valid_reg;
    assign bus.out0_data  = g_ch[0].data_reg;
    assign bus.out1_valid = g_ch[1].valid_reg;
    assign bus.out1_data  = g_ch[1].data_reg;
    assign cnt0           = g_ch[0].cnt_reg;
    assign cnt1           = g_ch[1].cnt_reg;
    assign rr_ptr         = rr_ptr_reg;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: a table of single-cycle vectors with
// hand-computed results, then a counter-wrap and mid-run reset sequence.
module tb_demux_1to2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cnt0, cnt1;
    logic       rr_ptr;

    int n_checks = 0;
    int n_errors = 0;

    demux_1to2_stream_if #(.WIDTH(8)) bus ();

    demux_1to2_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cnt0   (cnt0),
        .cnt1   (cnt1),
        .rr_ptr (rr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic       s;
        logic       am;
        logic       r0;
        logic       r1;
        logic [7:0] d;
        logic       e_ir;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
        logic       e_rr;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic am,
                         input logic [7:0] d, input logic r0, input logic r1);
        rst            = r;
        bus.in_valid   = v;
        bus.in_s       = s;
        bus.auto_mode  = am;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst v  s  am r0 r1 data    ir v0 d0     v1 d1     c0    c1    rr
        // explicit steering
        vecs[0]  = '{0, 1, 0, 0, 1, 1, 8'hA5,  1, 1, 8'hA5, 0, 8'h00, 8'd1, 8'd0, 0};
        vecs[1]  = '{0, 1, 1, 0, 1, 1, 8'h3C,  1, 0, 8'hA5, 1, 8'h3C, 8'd1, 8'd1, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 1, 8'h11,  1, 1, 8'h11, 0, 8'h3C, 8'd2, 8'd1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 1, 8'h00,  1, 0, 8'h11, 0, 8'h3C, 8'd2, 8'd1, 0};
        // reset with in_valid high: nothing accepted
        vecs[4]  = '{1, 1, 0, 0, 1, 1, 8'hEE,  1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0, 0};
        // round robin
        vecs[5]  = '{0, 1, 0, 1, 1, 1, 8'h01,  1, 1, 8'h01, 0, 8'h00, 8'd1, 8'd0, 1};
        vecs[6]  = '{0, 1, 0, 1, 1, 1, 8'h02,  1, 0, 8'h01, 1, 8'h02, 8'd1, 8'd1, 0};
        vecs[7]  = '{0, 1, 0, 1, 1, 1, 8'h03,  1, 1, 8'h03, 0, 8'h02, 8'd2, 8'd1, 1};
        vecs[8]  = '{0, 1, 0, 1, 1, 1, 8'h04,  1, 0, 8'h03, 1, 8'h04, 8'd2, 8'd2, 0};
        // independent backpressure
        vecs[9]  = '{0, 1, 0, 0, 0, 1, 8'h55,  1, 1, 8'h55, 0, 8'h04, 8'd3, 8'd2, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 1, 8'h77,  0, 1, 8'h55, 0, 8'h04, 8'd3, 8'd2, 0};
        vecs[11] = '{0, 1, 1, 0, 0, 1, 8'h66,  1, 1, 8'h55, 1, 8'h66, 8'd3, 8'd3, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 8'h00,  1, 0, 8'h55, 1, 8'h66, 8'd3, 8'd3, 0};
        // drain plus refill on channel 0
        vecs[13] = '{0, 1, 0, 0, 1, 1, 8'h10,  1, 1, 8'h10, 0, 8'h66, 8'd4, 8'd3, 0};
        vecs[14] = '{0, 1, 0, 0, 1, 1, 8'h20,  1, 1, 8'h20, 0, 8'h66, 8'd5, 8'd3, 0};
        vecs[15] = '{0, 0, 0, 0, 1, 1, 8'h00,  1, 0, 8'h20, 0, 8'h66, 8'd5, 8'd3, 0};
        // mode switching: in_s ignored in auto, pointer held on manual accept
        vecs[16] = '{0, 1, 1, 1, 1, 1, 8'hAA,  1, 1, 8'hAA, 0, 8'h66, 8'd6, 8'd3, 1};
        vecs[17] = '{0, 1, 0, 0, 1, 1, 8'hBB,  1, 1, 8'hBB, 0, 8'h66, 8'd7, 8'd3, 1};
        vecs[18] = '{0, 1, 0, 1, 1, 1, 8'hCC,  1, 0, 8'hBB, 1, 8'hCC, 8'd7, 8'd4, 0};

        // Initial reset: two cycles with in_valid asserted.
        drive(1, 1, 0, 0, 8'hFF, 1, 1);
        tick();
        tick();
        chk("reset_v0", bus.out0_valid, 0);
        chk("reset_v1", bus.out1_valid, 0);
        chk("reset_d0", bus.out0_data, 0);
        chk("reset_d1", bus.out1_data, 0);
        chk("reset_cnt0", cnt0, 0);
        chk("reset_cnt1", cnt1, 0);
        chk("reset_rr", rr_ptr, 0);
        $display("reset: v0=%0d v1=%0d cnt0=%0d cnt1=%0d rr=%0d",
                 bus.out0_valid, bus.out1_valid, cnt0, cnt1, rr_ptr);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].am, vecs[i].d,
                  vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].e_ir);
            tick();
            chk($sformatf("vec%0d_v0", i), bus.out0_valid, vecs[i].e_v0);
            chk($sformatf("vec%0d_d0", i), bus.out0_data, vecs[i].e_d0);
            chk($sformatf("vec%0d_v1", i), bus.out1_valid, vecs[i].e_v1);
            chk($sformatf("vec%0d_d1", i), bus.out1_data, vecs[i].e_d1);
            chk($sformatf("vec%0d_cnt0", i), cnt0, vecs[i].e_c0);
            chk($sformatf("vec%0d_cnt1", i), cnt1, vecs[i].e_c1);
            chk($sformatf("vec%0d_rr", i), rr_ptr, vecs[i].e_rr);
            $display("vec %0d: in=%02h s=%0d am=%0d -> v0=%0d d0=%02h v1=%0d d1=%02h cnt0=%0d cnt1=%0d rr=%0d",
                     i, vecs[i].d, vecs[i].s, vecs[i].am, bus.out0_valid, bus.out0_data,
                     bus.out1_valid, bus.out1_data, cnt0, cnt1, rr_ptr);
        end

        // Counter wrap on channel 1 from a clean state.
        drive(1, 0, 0, 0, 8'h00, 1, 1);
        tick();
        for (int i = 0; i < 255; i++) begin
            drive(0, 1, 1, 0, 8'(i), 1, 1);
            tick();
        end
        chk("wrap_cnt1_255", cnt1, 8'd255);
        chk("wrap_d1_last", bus.out1_data, 8'hFE);
        $display("wrap: 255 words pushed, cnt1=%0d", cnt1);
        drive(0, 1, 1, 0, 8'hFF, 1, 1);
        tick();
        chk("wrap_cnt1_0", cnt1, 8'd0);
        chk("wrap_cnt0", cnt0, 8'd0);
        chk("wrap_v1", bus.out1_valid, 1);
        $display("wrap: 256th word pushed, cnt1=%0d", cnt1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 8'hD0 + 8'(i), 1, 1);
            tick();
        end
        chk("post_wrap_cnt1", cnt1, 8'd3);
        chk("post_wrap_d1", bus.out1_data, 8'hD2);
        $display("wrap: 3 more words, cnt1=%0d d1=%02h", cnt1, bus.out1_data);

        // One auto-mode word to channel 0 (out1 stalled) so rr_ptr is 1.
        drive(0, 1, 0, 1, 8'hE0, 1, 0);
        tick();
        chk("pre_rst_rr", rr_ptr, 1);
        chk("pre_rst_v1", bus.out1_valid, 1);
        chk("pre_rst_d0", bus.out0_data, 8'hE0);
        $display("pre-reset: rr=%0d v1=%0d d0=%02h", rr_ptr, bus.out1_valid, bus.out0_data);

        // Mid-run reset pulse with a word pending and out1 holding data.
        drive(1, 1, 1, 0, 8'h99, 0, 0);
        tick();
        chk("midrst_v0", bus.out0_valid, 0);
        chk("midrst_v1", bus.out1_valid, 0);
        chk("midrst_cnt0", cnt0, 0);
        chk("midrst_cnt1", cnt1, 0);
        chk("midrst_rr", rr_ptr, 0);
        chk("midrst_d1", bus.out1_data, 0);
        $display("mid-run reset: v0=%0d v1=%0d cnt0=%0d cnt1=%0d rr=%0d",
                 bus.out0_valid, bus.out1_valid, cnt0, cnt1, rr_ptr);

        drive(0, 0, 0, 0, 8'h00, 1, 1);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
